// File: rtl/wm_timer.sv
// Phase timer for the washing-machine controller.
// Counts the cycles spent in each timed controller state. When a phase's
// duration expires, it raises that phase's completion flag. The flag stays
// high until the state changes or the timer is reset.
module wm_timer #(
  parameter int unsigned FILL_TIME  = 4,
  parameter int unsigned HEAT_TIME  = 4,
  parameter int unsigned WASH_TIME  = 6,
  parameter int unsigned RINSE_TIME = 5,
  parameter int unsigned SPIN_TIME  = 5,
  parameter int unsigned DRAIN_TIME = 3,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [2:0] state,
  output logic       sig_Full,
  output logic       sig_Temperature,
  output logic       sig_Completed
);

  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] ST_FILL  = 3'd1;
  localparam logic [STATE_W-1:0] ST_HEAT  = 3'd2;
  localparam logic [STATE_W-1:0] ST_WASH  = 3'd3;
  localparam logic [STATE_W-1:0] ST_RINSE = 3'd4;
  localparam logic [STATE_W-1:0] ST_SPIN  = 3'd5;
  localparam logic [STATE_W-1:0] ST_DRAIN = 3'd6;
  localparam logic [STATE_W-1:0] ST_DONE  = 3'd7;

  localparam logic [CNT_WIDTH-1:0] FILL_T  = CNT_WIDTH'(FILL_TIME);
  localparam logic [CNT_WIDTH-1:0] HEAT_T  = CNT_WIDTH'(HEAT_TIME);
  localparam logic [CNT_WIDTH-1:0] WASH_T  = CNT_WIDTH'(WASH_TIME);
  localparam logic [CNT_WIDTH-1:0] RINSE_T = CNT_WIDTH'(RINSE_TIME);
  localparam logic [CNT_WIDTH-1:0] SPIN_T  = CNT_WIDTH'(SPIN_TIME);
  localparam logic [CNT_WIDTH-1:0] DRAIN_T = CNT_WIDTH'(DRAIN_TIME);

  logic [STATE_W-1:0]   prev_q, prev_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 full_q, full_d;
  logic                 temp_q, temp_d;
  logic                 comp_q, comp_d;

  logic [CNT_WIDTH-1:0] dur_c;
  logic                 timed_c;
  logic                 entry_c;

  // Duration of the phase selected by the current state code; zero marks untimed states.
  always_comb begin
    dur_c = '0;
    case (state)
      ST_FILL:  dur_c = FILL_T;
      ST_HEAT:  dur_c = HEAT_T;
      ST_WASH:  dur_c = WASH_T;
      ST_RINSE: dur_c = RINSE_T;
      ST_SPIN:  dur_c = SPIN_T;
      ST_DRAIN: dur_c = DRAIN_T;
      ST_IDLE,
      ST_DONE:  dur_c = '0;
      default:  dur_c = '0;
    endcase
  end

  assign timed_c = (dur_c != '0);
  assign entry_c = (state != prev_q);

  // Next-state logic: restart on entry, count up to the duration and saturate there, then flag.
  always_comb begin
    prev_d  = prev_q;
    count_d = count_q;
    full_d  = 1'b0;
    temp_d  = 1'b0;
    comp_d  = 1'b0;

    if (entry_c) begin
      prev_d  = state;
      count_d = '0;
    end else if (!timed_c) begin
      count_d = '0;
    end else begin
      if (count_q < dur_c) begin
        count_d = count_q + CNT_WIDTH'(1);
      end
      if (count_d == dur_c) begin
        case (state)
          ST_FILL: full_d = 1'b1;
          ST_HEAT: temp_d = 1'b1;
          default: comp_d = 1'b1;
        endcase
      end
    end
  end

  // State, counter and output flops with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      prev_q  <= ST_IDLE;
      count_q <= '0;
      full_q  <= 1'b0;
      temp_q  <= 1'b0;
      comp_q  <= 1'b0;
    end else begin
      prev_q  <= prev_d;
      count_q <= count_d;
      full_q  <= full_d;
      temp_q  <= temp_d;
      comp_q  <= comp_d;
    end
  end

  assign sig_Full        = full_q;
  assign sig_Temperature = temp_q;
  assign sig_Completed   = comp_q;

endmodule

// File: tb/tb_wm_timer.sv
// Directed bench for wm_timer.
// A phase-level model tracks how many edges have passed since the last entry.
// It is checked against the DUT after every edge. Hand-computed literals at
// key points pin both the model and the DUT.
module tb_wm_timer;

  logic       clock;
  logic       reset_n;
  logic [2:0] state;
  logic       sig_Full;
  logic       sig_Temperature;
  logic       sig_Completed;

  int tests;
  int fails;

  // Model: code of the current phase and the number of hold edges since its entry.
  int m_phase;
  int m_held;

  wm_timer dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .state           (state),
    .sig_Full        (sig_Full),
    .sig_Temperature (sig_Temperature),
    .sig_Completed   (sig_Completed)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic int phase_len(input int ph);
    case (ph)
      1: return 4;
      2: return 4;
      3: return 6;
      4: return 5;
      5: return 5;
      6: return 3;
      default: return 0;
    endcase
  endfunction

  task automatic check1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of all outputs against the model.
  task automatic check_model();
    int  len;
    logic done;
    len  = phase_len(m_phase);
    done = (len > 0) && (m_held >= len);
    check1("model_full", sig_Full,        done && (m_phase == 1));
    check1("model_temp", sig_Temperature, done && (m_phase == 2));
    check1("model_comp", sig_Completed,   done && (m_phase >= 3) && (m_phase <= 6));
  endtask

  task automatic lit(input string name, input logic f, input logic t, input logic c);
    check1({name, "_full"}, sig_Full, f);
    check1({name, "_temp"}, sig_Temperature, t);
    check1({name, "_comp"}, sig_Completed, c);
  endtask

  // Apply inputs, take one rising edge, update the model, and compare after the edge.
  task automatic step(input logic [2:0] st, input logic rn);
    state   = st;
    reset_n = rn;
    @(posedge clock);
    if (!rn) begin
      m_phase = 0;
      m_held  = 0;
    end else if (int'(st) != m_phase) begin
      m_phase = int'(st);
      m_held  = 0;
    end else if (m_held < 1000) begin
      m_held++;
    end
    #1;
    check_model();
  endtask

  task automatic steps(input logic [2:0] st, input int n);
    for (int i = 0; i < n; i++) step(st, 1'b1);
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    m_phase = 0;
    m_held  = 0;
    state   = 3'd4;
    reset_n = 1'b0;

    // Reset held with RINSE on the input.
    step(3'd4, 1'b0);
    step(3'd4, 1'b0);
    lit("reset", 1'b0, 1'b0, 1'b0);

    // Release: the first edge is the entry, and the flag rises after edge 6.
    steps(3'd4, 5);
    lit("rinse_e5", 1'b0, 1'b0, 1'b0);
    step(3'd4, 1'b1);
    lit("rinse_e6", 1'b0, 1'b0, 1'b1);
    steps(3'd4, 3);
    lit("rinse_hold", 1'b0, 1'b0, 1'b1);

    // FILL, then HEAT.
    steps(3'd1, 4);
    lit("fill_e4", 1'b0, 1'b0, 1'b0);
    step(3'd1, 1'b1);
    lit("fill_e5", 1'b1, 1'b0, 1'b0);
    step(3'd2, 1'b1);
    lit("heat_entry", 1'b0, 1'b0, 1'b0);
    steps(3'd2, 3);
    lit("heat_e4", 1'b0, 1'b0, 1'b0);
    step(3'd2, 1'b1);
    lit("heat_e5", 1'b0, 1'b1, 1'b0);

    // Back-to-back WASH then RINSE: the shared flag must drop and restart.
    steps(3'd3, 7);
    lit("wash_e7", 1'b0, 1'b0, 1'b1);
    step(3'd4, 1'b1);
    lit("b2b_entry", 1'b0, 1'b0, 1'b0);
    steps(3'd4, 4);
    lit("b2b_e5", 1'b0, 1'b0, 1'b0);
    step(3'd4, 1'b1);
    lit("b2b_e6", 1'b0, 1'b0, 1'b1);

    // Abort WASH to IDLE, then return and require the full duration.
    steps(3'd3, 3);
    steps(3'd0, 2);
    lit("abort_idle", 1'b0, 1'b0, 1'b0);
    steps(3'd3, 6);
    lit("rewash_e6", 1'b0, 1'b0, 1'b0);
    step(3'd3, 1'b1);
    lit("rewash_e7", 1'b0, 1'b0, 1'b1);

    // Mid-phase reset during SPIN.
    steps(3'd5, 4);
    step(3'd5, 1'b0);
    lit("spin_rst", 1'b0, 1'b0, 1'b0);
    steps(3'd5, 5);
    lit("spin_e5", 1'b0, 1'b0, 1'b0);
    step(3'd5, 1'b1);
    lit("spin_e6", 1'b0, 1'b0, 1'b1);

    // Glitch DRAIN -> SPIN -> DRAIN: the phase restarts.
    steps(3'd6, 4);
    lit("drain_e4", 1'b0, 1'b0, 1'b1);
    step(3'd5, 1'b1);
    steps(3'd6, 3);
    lit("glitch_e3", 1'b0, 1'b0, 1'b0);
    step(3'd6, 1'b1);
    lit("glitch_e4", 1'b0, 1'b0, 1'b1);

    // DONE is untimed.
    steps(3'd7, 20);
    lit("done_hold", 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wm_timer.md
Name: wm_timer

Overview:
Phase timer for the washing-machine controller. It watches the controller's 3-bit state code and counts clock cycles spent in each timed phase. When a phase's programmed duration expires, it raises that phase's completion flag: sig_Full, sig_Temperature or sig_Completed. It sits beside the controller FSM, which uses these flags as its transition conditions.

Parameters:
FILL_TIME, 4, cycles to fill with water (state 1) before sig_Full
HEAT_TIME, 4, cycles to heat (state 2) before sig_Temperature
WASH_TIME, 6, cycles in wash (state 3) before sig_Completed
RINSE_TIME, 5, cycles in rinse (state 4) before sig_Completed
SPIN_TIME, 5, cycles in spin (state 5) before sig_Completed
DRAIN_TIME, 3, cycles in drain (state 6) before sig_Completed
CNT_WIDTH, 8, counter width; every *_TIME must be >=1 and <2^CNT_WIDTH

Ports:
clock  input  1  system clock, rising-edge active
reset_n  input  1  synchronous active-low reset
state  input  3  current controller state code
sig_Full  output  1  fill phase elapsed
sig_Temperature  output  1  heat phase elapsed
sig_Completed  output  1  wash/rinse/spin/drain phase elapsed

Behaviour:
- Interface decision: one clock; reset is synchronous and active-low (clock port named clock, reset port named reset_n).
- State codes:
  - 0 IDLE and 7 DONE are untimed.
  - 1 FILL, 2 HEAT, 3 WASH, 4 RINSE, 5 SPIN and 6 DRAIN are timed.
  - Each timed phase uses the duration parameter listed above.
- Internal registers: prev_state (3 bits), count (CNT_WIDTH bits), and the three output flops. All outputs are registered; there are no combinational paths from inputs to outputs.
- Reset (reset_n=0 at a rising edge): prev_state=0, count=0, all three outputs=0. Reset has priority over everything else.
- Entry edge (the first edge where state != prev_state):
  - prev_state <= state, count <= 0, all outputs <= 0.
  - After reset, a non-zero state therefore registers as an entry.
- Hold edges (state == prev_state) in a timed phase with duration T:
  - If count < T: count <= count+1.
  - When the new count equals T, assert that phase's flag on the same edge.
  - Once count == T, count saturates and the flag stays high until the state changes or reset.
  - Net latency: the flag is high after the (T+1)th rising edge counted from and including the entry edge.
- Flag mapping:
  - FILL drives sig_Full only.
  - HEAT drives sig_Temperature only.
  - WASH, RINSE, SPIN and DRAIN drive sig_Completed only.
  - At most one output is ever high.
- Untimed states (0, 7): count held at 0, all outputs 0.
- State change mid-count, including a change between two timed phases:
  - The count restarts on the entry edge and the previous flag drops on that edge.
  - No flag carries across states, even when two consecutive states share sig_Completed.
- State glitch back to the original code: treated as two entries, so the phase restarts.
- No wrap-around is possible because the count saturates at T.
- Reset mid-phase: all outputs drop on that edge. The first edge after release counts as an entry if state != 0.

Test Plan:
- Reset: reset_n=0 for 2 edges with state=4 -> all outputs 0, count 0; release with state=4 -> the first edge is the entry, and sig_Completed rises after edge 6 (RINSE_TIME=5) and stays high over 3 more edges.
- Fill: state=1 held -> sig_Full 0 after edges 1-4 and 1 after edge 5; sig_Temperature and sig_Completed remain 0; change state to 2 -> sig_Full drops on the next edge, and sig_Temperature rises 5 edges after entry.
- Back-to-back phases: WASH held 7 edges (sig_Completed=1), then state=4 -> sig_Completed=0 on the entry edge and rises again 6 edges later.
- Abort: state=3 held 3 edges, then state=0 -> outputs stay 0, count 0; return to 3 -> a full 7 edges are required.
- Mid-phase reset: state=5, count=3, assert reset_n=0 one edge -> outputs 0; release -> entry edge, then sig_Completed after 6 total edges.
- Untimed: state=7 held 20 edges -> all outputs remain 0.
